// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path: state encoding,
// register window layout and bus width.
package la_pkg;

    localparam int BUS_W = 16;

    // Capture controller states; the encoding is host-visible through the state register.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE      = 3'd1,
        ST_IN_POS    = 3'd2,
        ST_CAPTURING = 3'd3,
        ST_CAPTURED  = 3'd4
    } la_state_e;

    // Register offsets inside the block's window.
    localparam logic [2:0] REG_STATE = 3'd0;
    localparam logic [2:0] REG_TLOC  = 3'd1;
    localparam logic [2:0] REG_START = 3'd2;
    localparam logic [2:0] REG_STOP  = 3'd3;
    localparam logic [2:0] REG_RPTR  = 3'd4;
    localparam logic [2:0] REG_WPTR  = 3'd5;

    localparam logic [BUS_W-1:0] NUM_REGS = 16'd6;

endpackage

// File: rtl/la_capture_fsm.sv
// Capture controller: drives the write side of the circular sample memory,
// keeping trigger_loc pre-trigger samples ahead of the trigger, and exposes
// its control/status registers on the daisy-chained register bus.
module la_capture_fsm
    import la_pkg::*;
#(
    parameter logic [BUS_W-1:0] BASE_ADDR    = 16'h0000,
    parameter int               SAMPLE_DEPTH = 1024,
    parameter int               AW           = $clog2(SAMPLE_DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic [BUS_W-1:0] addr_i,
    input  logic [BUS_W-1:0] wdata_i,
    input  logic [BUS_W-1:0] rdata_i,
    input  logic             rw_i,
    input  logic             valid_i,
    output logic [BUS_W-1:0] addr_o,
    output logic [BUS_W-1:0] wdata_o,
    output logic [BUS_W-1:0] rdata_o,
    output logic             rw_o,
    output logic             valid_o,
    output logic [AW-1:0]    bram_addr,
    output logic             bram_we
);

    la_state_e        state;
    logic [AW-1:0]    tl;
    logic [BUS_W-1:0] req_start;
    logic [BUS_W-1:0] req_stop;
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;

    logic [BUS_W-1:0] off;
    logic             hit;
    logic             wr_hit;
    logic             rd_hit;
    logic             start_pulse;
    logic             stop_pulse;
    logic [AW-1:0]    tl_clamped;
    logic [BUS_W-1:0] rd_val;

    // Pointer step helpers; depth need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(SAMPLE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? AW'(SAMPLE_DEPTH - 1) : p - 1'b1;
    endfunction

    // Offset subtraction wraps, so a single compare gives the window hit.
    assign off    = addr_i - BASE_ADDR;
    assign hit    = (off < NUM_REGS);
    assign wr_hit = valid_i & rw_i & hit;
    assign rd_hit = valid_i & ~rw_i & hit;

    // Start/stop are edge-like: only a 0->1 write of the stored request fires.
    assign start_pulse = wr_hit && (off[2:0] == REG_START) && (wdata_i == 16'd1) && (req_start == '0);
    assign stop_pulse  = wr_hit && (off[2:0] == REG_STOP)  && (wdata_i == 16'd1) && (req_stop  == '0);

    assign bram_addr = wp;
    assign bram_we   = (state == ST_MOVE) || (state == ST_IN_POS) || (state == ST_CAPTURING);

    // Trigger location clamp and register readback mux.
    always_comb begin
        tl_clamped = AW'(wdata_i);
        if (32'(wdata_i) >= 32'(SAMPLE_DEPTH))
            tl_clamped = AW'(SAMPLE_DEPTH - 1);
        rd_val = '0;
        case (off[2:0])
            REG_STATE: rd_val = BUS_W'(state);
            REG_TLOC:  rd_val = BUS_W'(tl);
            REG_START: rd_val = req_start;
            REG_STOP:  rd_val = req_stop;
            REG_RPTR:  rd_val = BUS_W'(rp);
            REG_WPTR:  rd_val = BUS_W'(wp);
            default:   rd_val = '0;
        endcase
    end

    // Registered bus pass-through; reads inside the window substitute our data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_o  <= '0;
            wdata_o <= '0;
            rdata_o <= '0;
            rw_o    <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            addr_o  <= addr_i;
            wdata_o <= wdata_i;
            rdata_o <= rd_hit ? rd_val : rdata_i;
            rw_o    <= rw_i;
            valid_o <= valid_i;
        end
    end

    // Control registers, capture FSM and write/read pointer tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tl        <= '0;
            req_start <= '0;
            req_stop  <= '0;
            wp        <= '0;
            rp        <= '0;
        end else begin
            if (wr_hit) begin
                case (off[2:0])
                    REG_TLOC:  if (state == ST_IDLE) tl <= tl_clamped;
                    REG_START: req_start <= wdata_i;
                    REG_STOP:  req_stop  <= wdata_i;
                    default:   ;
                endcase
            end

            if (stop_pulse) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_pulse) begin
                            wp    <= '0;
                            rp    <= '0;
                            state <= (tl == '0) ? ST_IN_POS : ST_MOVE;
                        end
                    end
                    ST_MOVE: begin
                        // Fill the pre-trigger region; oldest sample stays at 0.
                        wp <= ptr_inc(wp);
                        if (wp == tl - 1'b1)
                            state <= ST_IN_POS;
                    end
                    ST_IN_POS: begin
                        // Sliding window: oldest sample tracks trigger_loc behind the writer.
                        wp <= ptr_inc(wp);
                        rp <= ptr_inc(rp);
                        if (trig)
                            state <= ST_CAPTURING;
                    end
                    ST_CAPTURING: begin
                        // Stop once the write lands just behind the oldest sample.
                        wp <= ptr_inc(wp);
                        if (wp == ptr_dec(rp))
                            state <= ST_CAPTURED;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
